// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Drives PC/IR/ALU/accumulator/memory enables, handles halt/trap and counts retired instructions.
module instruction_sequencer #(
   parameter int OPCODE_W    = 4,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                ir_load,
   output logic                pc_inc,
   output logic                pc_load,
   output logic [2:0]          alu_op,
   output logic                acc_we,
   output logic                fetch,
   output logic                decode,
   output logic                execute,
   output logic [2:0]          state,
   output logic                halted,
   output logic                trap,
   output logic [1:0]          trap_cause,
   output logic [CNT_W-1:0]    instr_count
);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXECUTE = 3'd3,
      S_MEM     = 3'd4,
      S_HALT    = 3'd5,
      S_TRAP    = 3'd6
   } state_t;

   state_t              state_reg, state_next;
   logic [OPCODE_W-1:0] op_reg;
   logic [1:0]          cause_reg, cause_next;
   logic [CNT_W-1:0]    count_reg;
   logic [WAIT_W-1:0]   wait_reg, wait_next;
   logic                retire;
   logic                timeout_hit;

   // Trap fires only when the last permitted cycle also lacks mem_ready.
   assign timeout_hit = !mem_ready && (wait_reg == WAIT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      state_next = state_reg;
      cause_next = cause_reg;
      wait_next  = '0;
      retire     = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_load    = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      alu_op     = 3'd0;
      acc_we     = 1'b0;
      fetch      = 1'b0;
      decode     = 1'b0;
      execute    = 1'b0;
      halted     = 1'b0;
      trap       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (run) state_next = S_FETCH;
         end
         S_FETCH: begin
            fetch   = 1'b1;
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_load    = 1'b1;
               pc_inc     = 1'b1;
               state_next = S_DECODE;
            end else if (timeout_hit) begin
               state_next = S_TRAP;
               cause_next = 2'b10;
            end else begin
               wait_next = wait_reg + WAIT_W'(1);
            end
         end
         S_DECODE: begin
            decode = 1'b1;
            if (opcode == OPCODE_W'(0) || opcode == OPCODE_W'(8) ||
                (opcode >= OPCODE_W'(3) && opcode <= OPCODE_W'(7))) begin
               state_next = S_EXECUTE;
            end else if (opcode == OPCODE_W'(1) || opcode == OPCODE_W'(2)) begin
               state_next = S_MEM;
            end else if (opcode == OPCODE_W'(15)) begin
               state_next = S_HALT;
            end else begin
               state_next = S_TRAP;
               cause_next = 2'b01;
            end
         end
         S_EXECUTE: begin
            execute = 1'b1;
            retire  = 1'b1;
            if (op_reg >= OPCODE_W'(3) && op_reg <= OPCODE_W'(7)) begin
               alu_op = op_reg[2:0];
               acc_we = 1'b1;
            end
            if (op_reg == OPCODE_W'(8)) pc_load = 1'b1;
            state_next = run ? S_FETCH : S_IDLE;
         end
         S_MEM: begin
            execute = 1'b1;
            mem_req = 1'b1;
            mem_we  = (op_reg == OPCODE_W'(2));
            if (mem_ready) begin
               acc_we     = (op_reg == OPCODE_W'(1));
               retire     = 1'b1;
               state_next = run ? S_FETCH : S_IDLE;
            end else if (timeout_hit) begin
               state_next = S_TRAP;
               cause_next = 2'b10;
            end else begin
               wait_next = wait_reg + WAIT_W'(1);
            end
         end
         S_HALT:  halted = 1'b1;
         S_TRAP:  trap   = 1'b1;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= S_IDLE;
         op_reg    <= '0;
         cause_reg <= 2'b00;
         count_reg <= '0;
         wait_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cause_reg <= cause_next;
         wait_reg  <= wait_next;
         if (state_reg == S_DECODE) op_reg <= opcode;
         if (retire && count_reg != '1) count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign state       = state_reg;
   assign trap_cause  = cause_reg;
   assign instr_count = count_reg;
endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized scoreboard bench for instruction_sequencer: an instruction-level model
// predicts strobe events and retirement counts; a monitor pops and compares them.
module tb_instruction_sequencer;
   localparam int MT = 15;
   localparam int EV_IR = 0, EV_ACC = 1, EV_LD = 2, EV_PC = 3, EV_ST = 4, EV_HALT = 5, EV_TRAP = 6;

   logic clk = 1'b0, reset = 1'b0, run = 1'b0, mem_ready = 1'b0;
   logic [3:0] opcode = 4'd0;
   logic mem_req, mem_we, ir_load, pc_inc, pc_load, acc_we, fetch, decode, execute, halted, trap;
   logic [2:0] alu_op, state;
   logic [1:0] trap_cause;
   logic [15:0] instr_count;
   logic s_mem_req, s_mem_we, s_ir_load, s_pc_inc, s_pc_load, s_acc_we, s_fetch, s_decode, s_execute, s_halted, s_trap;
   logic [2:0] s_alu_op, s_state;
   logic [1:0] s_trap_cause, s_instr_count;

   instruction_sequencer #(.OPCODE_W(4), .MEM_TIMEOUT(MT), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
      .alu_op(alu_op), .acc_we(acc_we), .fetch(fetch), .decode(decode), .execute(execute),
      .state(state), .halted(halted), .trap(trap), .trap_cause(trap_cause), .instr_count(instr_count));

   // Narrow-counter instance shares all stimulus; only its count differs.
   instruction_sequencer #(.OPCODE_W(4), .MEM_TIMEOUT(MT), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(s_mem_req), .mem_we(s_mem_we), .ir_load(s_ir_load), .pc_inc(s_pc_inc), .pc_load(s_pc_load),
      .alu_op(s_alu_op), .acc_we(s_acc_we), .fetch(s_fetch), .decode(s_decode), .execute(s_execute),
      .state(s_state), .halted(s_halted), .trap(s_trap), .trap_cause(s_trap_cause), .instr_count(s_instr_count));

   always #5 clk = ~clk;

   typedef struct { int kind; int alu; int cause; int cnt; int sat; } ev_t;
   ev_t exp_q[$];
   int n_checks = 0, n_fail = 0;
   int retired = 0;

   task automatic check_eq(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int kind, input int alu, input int cause);
      ev_t e;
      e.kind = kind; e.alu = alu; e.cause = cause;
      e.cnt = retired; e.sat = (retired > 3) ? 3 : retired;
      exp_q.push_back(e);
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_state"}, state, 0);
      check_eq({tag, "_count"}, instr_count, 0);
      check_eq({tag, "_outputs"}, {mem_req, mem_we, ir_load, pc_inc, pc_load, alu_op, acc_we,
                                   fetch, decode, execute, halted, trap, trap_cause}, 0);
      check_eq({tag, "_sat_outputs"}, {s_mem_req, s_mem_we, s_ir_load, s_pc_inc, s_pc_load, s_alu_op, s_acc_we,
                                       s_fetch, s_decode, s_execute, s_halted, s_trap, s_trap_cause,
                                       s_state, s_instr_count}, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; run = 1'b0; mem_ready = 1'b0;
      #1;
      check_zero("reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      retired = 0;
   endtask

   task automatic wait_fetch();
      int n = 0;
      while (!fetch && n < 30) begin
         @(negedge clk);
         n++;
      end
      check_eq("reach_fetch", fetch, 1);
   endtask

   // mem_ready low for d cycles, then high for one cycle.
   task automatic do_access(input int d, input bit is_store);
      for (int i = 0; i < d; i++) begin
         mem_ready = 1'b0;
         if (is_store) begin
            #1;
            check_eq("store_we_held", mem_we, 1);
         end
         @(negedge clk);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
   endtask

   task automatic timeout_hold();
      for (int i = 1; i <= MT; i++) begin
         mem_ready = 1'b0;
         #1;
         check_eq("no_trap_before_timeout", trap, 0);
         check_eq("mem_req_while_waiting", mem_req, 1);
         @(negedge clk);
      end
      #1;
      check_eq("trap_at_timeout", trap, 1);
      check_eq("mem_req_after_trap", mem_req, 0);
      check_eq("cause_timeout", trap_cause, 2);
   endtask

   task automatic do_instr(input int op, input int fd, input int md, input bit drop, output bit term);
      bit is_mem, is_exec;
      is_mem  = (op == 1 || op == 2);
      is_exec = (op == 0 || (op >= 3 && op <= 8));
      term = 1'b0;
      wait_fetch();
      if (fd >= MT) begin
         push(EV_TRAP, 0, 2);
         timeout_hold();
         term = 1'b1;
         return;
      end
      push(EV_IR, 0, 0);
      if (is_exec) begin
         if (op >= 3 && op <= 7) push(EV_ACC, op & 7, 0);
         else if (op == 8) push(EV_PC, 0, 0);
      end else if (is_mem) begin
         if (md >= MT) push(EV_TRAP, 0, 2);
         else if (op == 1) push(EV_LD, 0, 0);
         else push(EV_ST, 0, 0);
      end else if (op == 15) begin
         push(EV_HALT, 0, 0);
      end else begin
         push(EV_TRAP, 0, 1);
      end
      opcode = 4'($urandom);
      do_access(fd, 1'b0);
      check_eq("decode_state", state, 2);
      opcode = 4'(op);
      if (drop) run = 1'b0;
      @(negedge clk);
      if (is_exec) begin
         retired++;
      end else if (is_mem) begin
         if (md >= MT) begin
            timeout_hold();
            term = 1'b1;
         end else begin
            do_access(md, op == 2);
            retired++;
         end
      end else begin
         term = 1'b1;
      end
      if (drop && !term) begin
         if (is_exec) @(negedge clk);
         repeat (3) begin
            check_eq("idle_after_run_drop", state, 0);
            @(negedge clk);
         end
         check_eq("count_after_run_drop", instr_count, retired);
         run = 1'b1;
         @(negedge clk);
         check_eq("fetch_after_run_return", fetch, 1);
      end
   endtask

   function automatic int rand_delay();
      return ($urandom_range(0, 9) == 0) ? MT - 1 : int'($urandom_range(0, 3));
   endfunction

   // Monitor: classify each observed strobe event and compare with the model's queue.
   initial begin : monitor
      ev_t e;
      int kind;
      bit halt_prev, trap_prev;
      halt_prev = 1'b0; trap_prev = 1'b0;
      forever begin
         @(negedge clk);
         #3;
         kind = -1;
         if (ir_load) kind = EV_IR;
         else if (acc_we && mem_req) kind = EV_LD;
         else if (acc_we) kind = EV_ACC;
         else if (pc_load) kind = EV_PC;
         else if (mem_req && mem_we && mem_ready) kind = EV_ST;
         else if (halted && !halt_prev) kind = EV_HALT;
         else if (trap && !trap_prev) kind = EV_TRAP;
         if (kind >= 0) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_event", kind, -1);
            end else begin
               e = exp_q.pop_front();
               check_eq("event_kind", kind, e.kind);
               check_eq("event_count", instr_count, e.cnt);
               check_eq("event_sat_count", s_instr_count, e.sat);
               if (kind == EV_ACC) check_eq("alu_op", alu_op, e.alu);
               if (kind == EV_TRAP) check_eq("trap_cause", trap_cause, e.cause);
               if (kind == EV_IR) check_eq("pc_inc_with_ir_load", pc_inc, 1);
            end
         end
         halt_prev = halted;
         trap_prev = trap;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      bit term;
      int n, op, tsel;
      bit exp_halt;
      do_reset();
      run = 1'b1;
      for (int seg = 0; seg < 8; seg++) begin
         if (seg == 0) begin
            for (int k = 0; k < 4; k++) do_instr(3, 0, 0, 1'b0, term);
            do_instr(1, MT - 1, MT - 1, 1'b0, term);
            do_instr(2, 2, MT - 1, 1'b0, term);
            do_instr(5, 0, 0, 1'b1, term);
         end
         n = $urandom_range(4, 12);
         for (int k = 0; k < n; k++) begin
            op = $urandom_range(0, 8);
            do_instr(op, rand_delay(), rand_delay(), $urandom_range(0, 7) == 0, term);
         end
         tsel = seg % 4;
         exp_halt = (tsel == 0);
         case (tsel)
            0: do_instr(15, rand_delay(), 0, 1'b0, term);
            1: do_instr($urandom_range(9, 14), rand_delay(), 0, 1'b0, term);
            2: do_instr(3, MT, 0, 1'b0, term);
            default: do_instr($urandom_range(1, 2), rand_delay(), MT, 1'b0, term);
         endcase
         check_eq("terminal_reached", term, 1);
         for (int k = 0; k < 6; k++) begin
            run = 1'($urandom);
            @(negedge clk);
            #1;
            check_eq("stays_halted", halted, exp_halt);
            check_eq("stays_trapped", trap, !exp_halt);
            check_eq("terminal_count_frozen", instr_count, retired);
            check_eq("terminal_no_mem_req", mem_req, 0);
         end
         check_eq("queue_drained", exp_q.size(), 0);
         do_reset();
         run = 1'b1;
      end
      // Asynchronous reset while a LOAD is waiting in MEM.
      do_instr(0, 0, 0, 1'b0, term);
      do_instr(4, 1, 0, 1'b0, term);
      wait_fetch();
      push(EV_IR, 0, 0);
      do_access(0, 1'b0);
      opcode = 4'd1;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check_eq("mem_req_in_mem", mem_req, 1);
      check_eq("count_before_async_reset", instr_count, retired);
      #1;
      reset = 1'b0;
      run = 1'b0;
      #1;
      check_zero("async_reset");
      check_eq("queue_drained_final", exp_q.size(), 0);
      @(negedge clk);
      reset = 1'b1;
      retired = 0;
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Multi-cycle control unit for the 8-bit accumulator CPU; extends the fetch/decode/execute cycle FSM.
- Adds a memory handshake, opcode-dependent sequencing, halt/trap handling and a retired-instruction counter.
- Sits between the instruction register/opcode decoder and the PC, IR, ALU, accumulator and memory port, and drives their enables.

Parameters:
- OPCODE_W, 4, opcode width.
- MEM_TIMEOUT, 15, cycles allowed in FETCH/MEM without mem_ready before trap (>=2).
- CNT_W, 16, width of instr_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- run  in  1  enable execution; sampled at instruction boundaries.
- opcode  in  OPCODE_W  current instruction register opcode; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier; only meaningful with mem_req.
- ir_load  out  1  load instruction register.
- pc_inc  out  1  increment PC.
- pc_load  out  1  load PC from operand (JMP).
- alu_op  out  3  ALU function select.
- acc_we  out  1  accumulator write enable.
- fetch / decode / execute  out  1 each  phase indicators.
- state  out  3  encoded state, for debug.
- halted  out  1  HALT state.
- trap  out  1  TRAP state.
- trap_cause  out  2  01 illegal opcode, 10 memory timeout, 00 none.
- instr_count  out  CNT_W  retired instructions, saturating.

Behaviour:
- Reset (reset=0, any time, mid-access included):
  - state=IDLE (0).
  - All strobes 0; trap_cause=00; instr_count=0; wait counter=0; latched opcode=0.
  - The access in flight is abandoned; mem_req drops immediately.
- Outputs:
  - Strobes and indicators decode combinationally from state, the latched opcode and mem_ready.
  - state, trap_cause and instr_count are registered.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, HALT=5, TRAP=6.
- IDLE: all strobes 0; run=1 -> FETCH next cycle.
- FETCH:
  - fetch=1, mem_req=1, mem_we=0.
  - On a mem_ready cycle: ir_load=1 and pc_inc=1 that same cycle -> DECODE.
- DECODE:
  - decode=1 for one cycle; latches opcode.
  - Next state by opcode:
    - 0x0 NOP, 0x3-0x7 ALU, 0x8 JMP -> EXECUTE.
    - 0x1 LOAD, 0x2 STORE -> MEM.
    - 0xF -> HALT.
    - Any other opcode -> TRAP, trap_cause=01.
- EXECUTE:
  - execute=1 for one cycle.
  - ALU opcodes: alu_op=opcode[2:0], acc_we=1. JMP: pc_load=1. NOP: no strobes.
  - Next state: FETCH if run=1, else IDLE.
- MEM:
  - execute=1, mem_req=1, mem_we=1 for STORE only.
  - LOAD: acc_we=1 on the mem_ready cycle.
  - On mem_ready: FETCH if run=1, else IDLE.
- Retirement: leaving EXECUTE or MEM increments instr_count; it saturates at all-ones. HALT does not count.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle mem_ready=0.
  - If mem_ready=0 in the MEM_TIMEOUT-th consecutive cycle of the state -> TRAP, trap_cause=10, mem_req drops next cycle.
  - mem_ready=1 in that cycle wins: no trap.
- HALT: halted=1, all strobes 0; exits only by reset; run is ignored.
- TRAP: trap=1, trap_cause held, all strobes 0; exits only by reset.
- run=0 mid-instruction: the current instruction completes; the block stops at the next boundary in IDLE.
- Minimum latency, mem_ready tied to 1:
  - NOP/ALU/JMP: 3 cycles (FETCH, DECODE, EXECUTE).
  - LOAD/STORE: 3 cycles (FETCH, DECODE, MEM).

Test Plan:
- Reset then run=1, mem_ready=1, opcode=0x3 -> states 1,2,3 repeat; acc_we=1 with alu_op=3 in EXECUTE; instr_count=1 after first EXECUTE, 4 after 12 cycles.
- LOAD with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, acc_we pulses only on the ready cycle; STORE has mem_we=1 throughout MEM.
- FETCH with mem_ready never asserted, MEM_TIMEOUT=15 -> TRAP on the 16th clock after FETCH entry, trap_cause=10, mem_req=0; stays until reset. Repeat with ready on cycle 15 -> no trap.
- opcode=0xA -> TRAP after DECODE, trap_cause=01; opcode=0xF -> halted=1, instr_count unchanged, run toggling ignored.
- Drop run during DECODE -> EXECUTE completes, instr_count+1, then IDLE; reassert run -> FETCH next cycle.
- Assert reset=0 mid-MEM with mem_req=1 -> mem_req and all outputs 0 immediately (asynchronous); state=0, instr_count=0; CNT_W=2 run -> count saturates at 3.
